primem_arbiter: RTL
===================

Name: primem_arbiter

Overview:
- Shares the core's single memory port between instruction fetch and the execute stage's load/store path.
- Arbitrates round-robin between the two requesters and sequences one bus transaction at a time with a valid/ready handshake.
- Generates byte strobes and lane-replicated store data, and right-aligns load data for the execute stage's sign extension.
- Flags misaligned or illegal accesses and bus timeouts to the requester.

Parameters:
TIMEOUT_CYCLES, 255, max cycles mem_valid is held without mem_ready before abort; 0 disables timeout

Ports:
clk_i  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch request; held with if_addr stable until if_done
if_addr  input  32  fetch byte address
if_rdata  output  32  fetched word, valid while if_done=1
if_done  output  1  one-cycle completion pulse
if_err  output  1  with if_done: misaligned or timeout
d_req  input  1  load/store request; held with fields stable until d_done
d_we  input  1  1 = store, 0 = load
d_size  input  2  00 byte, 01 half, 10 word, 11 illegal
d_addr  input  32  data byte address
d_wdata  input  32  store data, right-aligned
d_rdata  output  32  load data right-aligned, zero-extended to 32, valid while d_done=1
d_done  output  1  one-cycle completion pulse
d_err  output  1  with d_done: misaligned, illegal size or timeout
mem_valid  output  1  bus request, registered
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_wdata  output  32  lane-replicated store data
mem_wstrb  output  4  byte strobes; 0000 for reads and fetches
mem_rdata  input  32  bus read data, sampled when mem_valid&&mem_ready
mem_ready  input  1  bus accept/complete

Behaviour:
- Reset (async, any state): state=IDLE, last_grant=DATA. All outputs 0. Timeout counter 0. No done pulse is generated for an aborted transaction.
- States:
  - IDLE: requesters are sampled.
  - BUSY_I: fetch transaction outstanding.
  - BUSY_D: data transaction outstanding.
- Eligibility in IDLE: a requester is eligible when req=1 and its own done output is 0. This blocks re-issue during the completion cycle while req is still high.
- Grant:
  - One eligible requester: grant it.
  - Both eligible: grant the one not equal to last_grant. After reset, fetch wins first.
  - last_grant updates at every grant, including error completions.
- Alignment check at grant:
  - Fetch: if_addr[1:0]!=0 is an error.
  - Data: half with addr[0]=1, word with addr[1:0]!=0, or d_size=11 is an error.
  - On error: no bus cycle. Next edge drives done=1, err=1, rdata=0. State stays IDLE.
- Legal grant: next edge drives mem_valid=1, mem_addr, mem_wdata and mem_wstrb from the granted fields, then enters BUSY_x. Outputs are held constant until completion.
- Store lanes (off = addr[1:0]):
  - Byte: wdata = {4{d_wdata[7:0]}}, wstrb = 0001<<off.
  - Half: wdata = {2{d_wdata[15:0]}}, wstrb = 0011<<off.
  - Word: wdata = d_wdata, wstrb = 1111.
  - Loads and fetches: wstrb = 0000, wdata = 0.
- Completion: at the edge with mem_valid&&mem_ready:
  - mem_valid=0, state=IDLE.
  - Granted done=1, err=0.
  - Load rdata = (mem_rdata >> 8*off), masked to 8/16/32 bits per size.
  - Store rdata = 0. if_rdata = mem_rdata.
- Minimum latency: request seen in IDLE at edge N; mem_valid high after N; with mem_ready already 1, done high after N+1.
- Timeout:
  - Counter increments each BUSY cycle without ready.
  - When it reaches TIMEOUT_CYCLES, at that edge: mem_valid=0, done=1, err=1, rdata=0, state=IDLE.
  - Counter clears on entry to BUSY.
  - If mem_ready and timeout coincide, ready wins (normal completion).
- done and err are single-cycle pulses. Non-granted outputs stay 0 in that cycle.
- Requests arriving while BUSY wait; no queuing beyond the held req level.
- mem_ready while mem_valid=0 is ignored.

Test Plan:
- Word load: d_req, d_we=0, d_size=10, d_addr=0x100, mem_ready=1 -> mem_valid one cycle at 0x100, wstrb=0000; d_done next cycle, d_rdata=mem_rdata.
- Byte store: d_size=00, addr=0x203, d_wdata=0x000000A5 -> mem_addr=0x200, wdata=0xA5A5A5A5, wstrb=1000. Half load at addr 0x202, mem_rdata=0xBEEF1234 -> d_rdata=0x0000BEEF.
- Contention: if_req and d_req both high from reset, mem_ready=1 -> fetch served first, then data, then fetch. Grants alternate; no requester served twice in a row while the other is pending.
- Misaligned or illegal: word at 0x102, half at 0x101, and d_size=11 each give d_done=1, d_err=1 with no mem_valid. Fetch at 0x2 gives if_err=1.
- Timeout: TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_valid drops and d_done=1, d_err=1 after exactly 4 BUSY cycles. Ready asserted on the 4th cycle gives normal completion.
- Reset mid-transaction: rst_n low while BUSY_D -> mem_valid=0 immediately, no done pulse; after release, fetch is granted first.

Source files
------------

// File: rtl/primem_arbiter_if.sv
// rtl/primem_arbiter_if.sv - memory port bundle shared by fetch and load/store
interface primem_arbiter_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/primem_arbiter.sv
// rtl/primem_arbiter.sv - round-robin fetch/data arbiter for the single memory port
module primem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic [31:0]        if_rdata,
    output logic               if_done,
    output logic               if_err,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [1:0]         d_size,
    input  logic [31:0]        d_addr,
    input  logic [31:0]        d_wdata,
    output logic [31:0]        d_rdata,
    output logic               d_done,
    output logic               d_err,
    primem_arbiter_if.master   mem
);
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t      state, state_n;
    logic        last_data, last_n;
    logic [31:0] cnt, cnt_n;
    logic [1:0]  off_q, off_n, size_q, size_n;
    logic        we_q, we_n;
    logic        valid_n;
    logic [31:0] addr_n, wdata_n;
    logic [3:0]  wstrb_n;
    logic        if_done_n, if_err_n, d_done_n, d_err_n;
    logic [31:0] if_rdata_n, d_rdata_n;

    // A requester whose done pulse is still showing must not be re-granted.
    logic if_elig, d_elig, grant_i, grant_d, if_bad, d_bad;
    assign if_elig = if_req && !if_done;
    assign d_elig  = d_req && !d_done;
    assign grant_d = d_elig && (!if_elig || !last_data);
    assign grant_i = if_elig && !grant_d;
    assign if_bad  = (if_addr[1:0] != 2'b00);
    assign d_bad   = (d_size == 2'b11) ||
                     (d_size == 2'b01 && d_addr[0]) ||
                     (d_size == 2'b10 && d_addr[1:0] != 2'b00);

    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    always_comb begin
        st_wdata = 32'd0;
        st_wstrb = 4'b0000;
        if (d_we) begin
            case (d_size)
                2'b00:   begin st_wdata = {4{d_wdata[7:0]}};  st_wstrb = 4'b0001 << d_addr[1:0]; end
                2'b01:   begin st_wdata = {2{d_wdata[15:0]}}; st_wstrb = 4'b0011 << d_addr[1:0]; end
                default: begin st_wdata = d_wdata;            st_wstrb = 4'b1111; end
            endcase
        end
    end

    logic [31:0] shifted, load_data;
    assign shifted = mem.mem_rdata >> {off_q, 3'b000};
    always_comb begin
        case (size_q)
            2'b00:   load_data = {24'd0, shifted[7:0]};
            2'b01:   load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_n    = state;
        last_n     = last_data;
        cnt_n      = cnt;
        off_n      = off_q;
        size_n     = size_q;
        we_n       = we_q;
        valid_n    = mem.mem_valid;
        addr_n     = mem.mem_addr;
        wdata_n    = mem.mem_wdata;
        wstrb_n    = mem.mem_wstrb;
        if_done_n  = 1'b0;
        if_err_n   = 1'b0;
        if_rdata_n = 32'd0;
        d_done_n   = 1'b0;
        d_err_n    = 1'b0;
        d_rdata_n  = 32'd0;
        case (state)
            IDLE: begin
                if (grant_i) begin
                    last_n = 1'b0;
                    if (if_bad) begin
                        if_done_n = 1'b1;
                        if_err_n  = 1'b1;
                    end else begin
                        valid_n = 1'b1;
                        addr_n  = {if_addr[31:2], 2'b00};
                        wdata_n = 32'd0;
                        wstrb_n = 4'b0000;
                        cnt_n   = 32'd0;
                        state_n = BUSY_I;
                    end
                end else if (grant_d) begin
                    last_n = 1'b1;
                    if (d_bad) begin
                        d_done_n = 1'b1;
                        d_err_n  = 1'b1;
                    end else begin
                        valid_n = 1'b1;
                        addr_n  = {d_addr[31:2], 2'b00};
                        wdata_n = st_wdata;
                        wstrb_n = st_wstrb;
                        off_n   = d_addr[1:0];
                        size_n  = d_size;
                        we_n    = d_we;
                        cnt_n   = 32'd0;
                        state_n = BUSY_D;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                // Ready on the final timeout cycle still completes normally.
                if (mem.mem_ready) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                    if (state == BUSY_I) begin
                        if_done_n  = 1'b1;
                        if_rdata_n = mem.mem_rdata;
                    end else begin
                        d_done_n  = 1'b1;
                        d_rdata_n = we_q ? 32'd0 : load_data;
                    end
                end else if (TO_LIMIT != 32'd0 && cnt + 32'd1 == TO_LIMIT) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                    if (state == BUSY_I) begin
                        if_done_n = 1'b1;
                        if_err_n  = 1'b1;
                    end else begin
                        d_done_n = 1'b1;
                        d_err_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_data     <= 1'b1;
            cnt           <= 32'd0;
            off_q         <= 2'b00;
            size_q        <= 2'b00;
            we_q          <= 1'b0;
            mem.mem_valid <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_wdata <= 32'd0;
            mem.mem_wstrb <= 4'b0000;
            if_done       <= 1'b0;
            if_err        <= 1'b0;
            if_rdata      <= 32'd0;
            d_done        <= 1'b0;
            d_err         <= 1'b0;
            d_rdata       <= 32'd0;
        end else begin
            state         <= state_n;
            last_data     <= last_n;
            cnt           <= cnt_n;
            off_q         <= off_n;
            size_q        <= size_n;
            we_q          <= we_n;
            mem.mem_valid <= valid_n;
            mem.mem_addr  <= addr_n;
            mem.mem_wdata <= wdata_n;
            mem.mem_wstrb <= wstrb_n;
            if_done       <= if_done_n;
            if_err        <= if_err_n;
            if_rdata      <= if_rdata_n;
            d_done        <= d_done_n;
            d_err         <= d_err_n;
            d_rdata       <= d_rdata_n;
        end
    end
endmodule
